// File: rtl/fifo_pkg.sv
// Shared constants and ring-pointer helper for the FIFO read-side stream adapter.
package fifo_pkg;

   localparam int RD_BUF_DEPTH = 3;
   localparam int WORD_CNT_W   = 16;

   typedef logic [1:0] ring_ptr_t;

   // Advance a ring pointer over a 3-entry ring (2 wraps to 0).
   function automatic ring_ptr_t ptr_inc(input ring_ptr_t p);
      ring_ptr_t n_s;
      if (p == 2'd2) begin
         n_s = 2'd0;
      end else begin
         n_s = p + 2'd1;
      end
      return n_s;
   endfunction

endpackage

// File: rtl/rd_out_buf.sv
// Three-entry ring buffer holding words returned by the FIFO until the
// downstream stream accepts them. Clear has priority over push/pop.
module rd_out_buf
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head_data
);

   logic [WIDTH-1:0] mem_r [RD_BUF_DEPTH];
   ring_ptr_t        head_r;
   ring_ptr_t        tail_r;
   logic [1:0]       cnt_r;

   // Word storage; contents are don't-care once dropped, so no reset.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_r[tail_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push+pop keeps the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r <= 2'd0;
         tail_r <= 2'd0;
         cnt_r  <= 2'd0;
      end else if (clear) begin
         head_r <= 2'd0;
         tail_r <= 2'd0;
         cnt_r  <= 2'd0;
      end else begin
         if (push) begin
            tail_r <= ptr_inc(tail_r);
         end
         if (pop) begin
            head_r <= ptr_inc(head_r);
         end
         case ({push, pop})
            2'b10:   cnt_r <= cnt_r + 2'd1;
            2'b01:   cnt_r <= cnt_r - 2'd1;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign count     = cnt_r;
   assign head_data = mem_r[head_r];

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a FIFO read port with one-cycle read latency into a valid/ready
// stream. Reads are issued on credit (buffered + in-flight words below the
// buffer depth) so the buffer never overflows and m_ready never reaches
// fifo_rd_en combinationally.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BUF_DEPTH = 3
) (
   input  logic                  rd_clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [WIDTH-1:0]      fifo_rdata,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WIDTH-1:0]      m_data,
   input  logic                  flush,
   output logic [WORD_CNT_W-1:0] word_cnt
);

   localparam logic [2:0] CREDIT_LIM = 3'(BUF_DEPTH);

   logic                  inflight_r;
   logic [WORD_CNT_W-1:0] word_cnt_r;
   logic [1:0]            buf_cnt_s;
   logic [WIDTH-1:0]      head_data_s;
   logic [2:0]            credit_sum_s;
   logic                  rd_en_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  m_valid_s;

   assign m_valid_s = (buf_cnt_s != 2'd0);
   assign push_s    = inflight_r && !flush;
   assign pop_s     = m_valid_s && m_ready;

   rd_out_buf #(
      .WIDTH (WIDTH)
   ) u_out_buf (
      .clk       (rd_clk),
      .rst_n     (rst_n),
      .clear     (flush),
      .push      (push_s),
      .push_data (fifo_rdata),
      .pop       (pop_s),
      .count     (buf_cnt_s),
      .head_data (head_data_s)
   );

   // Read credit: only registered state plus FIFO flags; held off in reset.
   always_comb begin
      credit_sum_s = {1'b0, buf_cnt_s} + {2'b00, inflight_r};
      if (rst_n && !fifo_empty && !flush && (credit_sum_s < CREDIT_LIM)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   // Track the read issued last cycle; its data arrives on this edge.
   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= rd_en_s;
      end
   end

   // Delivered-word counter; wraps naturally and survives flush.
   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_r <= {WORD_CNT_W{1'b0}};
      end else if (pop_s) begin
         word_cnt_r <= word_cnt_r + WORD_CNT_W'(1);
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

   assign fifo_rd_en = rd_en_s;
   assign m_valid    = m_valid_s;
   assign m_data     = head_data_s;
   assign word_cnt   = word_cnt_r;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural FIFO model with
// one-cycle read latency, expected-word queue checked at every accept.
module tb_fifo_rd_stream;

   logic        rd_clk     = 1'b0;
   logic        rst_n      = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_rdata = 8'h00;
   logic        fifo_rd_en;
   logic        m_valid;
   logic        m_ready    = 1'b1;
   logic [7:0]  m_data;
   logic        flush      = 1'b0;
   logic [15:0] word_cnt;

   int          checks     = 0;
   int          errs       = 0;
   int          fifo_pops  = 0;
   int          dlv        = 0;
   int          dropped    = 0;
   logic [15:0] cnt_model  = 16'h0000;
   logic [7:0]  sb_exp;
   logic [7:0]  fifo_q[$];
   logic [7:0]  exp_q[$];

   fifo_rd_stream #(
      .WIDTH     (8),
      .BUF_DEPTH (3)
   ) dut (
      .rd_clk     (rd_clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rd_en (fifo_rd_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .flush      (flush),
      .word_cnt   (word_cnt)
   );

   always #5 rd_clk = ~rd_clk;

   // FIFO model: pop on rd_en, data registered one cycle later.
   always @(posedge rd_clk) begin
      if (fifo_rd_en && fifo_q.size() != 0) begin
         fifo_rdata <= fifo_q.pop_front();
         fifo_pops++;
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   // Scoreboard: every accepted word must be the next expected one.
   always @(negedge rd_clk) begin
      if (fifo_rd_en) begin
         checks++;
         if (fifo_empty) begin
            errs++;
            $display("FAIL rd_en_while_empty: fifo_rd_en=1 with fifo_empty=1, required 0");
         end
      end
      if (rst_n && m_valid && m_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL stream_extra: got %h, no word expected", m_data);
         end else begin
            sb_exp = exp_q.pop_front();
            if (m_data !== sb_exp) begin
               errs++;
               $display("FAIL stream_data: got %h expected %h", m_data, sb_exp);
            end
         end
         dlv++;
         cnt_model = cnt_model + 16'd1;
      end
   end

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push_words(input logic [7:0] base, input int n);
      logic [7:0] v;
      for (int i = 0; i < n; i++) begin
         v = base + 8'(i);
         fifo_q.push_back(v);
         exp_q.push_back(v);
      end
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         tick();
         c++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errs++;
         $display("FAIL drain_timeout: %0d words left after %0d cycles, required 0", exp_q.size(), budget);
      end
      tick();
      tick();
   endtask

   task automatic discard_pending(output int n);
      n = fifo_pops - dlv - dropped;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      dropped += n;
   endtask

   task automatic wait_valid();
      int c = 0;
      @(negedge rd_clk);
      while (!m_valid && c < 20) begin
         tick();
         @(negedge rd_clk);
         c++;
      end
      checks++;
      if (!m_valid) begin
         errs++;
         $display("FAIL wait_valid: m_valid=%b after 20 cycles, required 1", m_valid);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
      checks++;
      if (fifo_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
      checks++;
      if (word_cnt !== 16'h0000) begin errs++; $display("FAIL reset_word_cnt: got %h expected 0000", word_cnt); end
      push_words(8'h11, 8);
      tick();
      @(negedge rd_clk);
      checks++;
      if (fifo_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_gate: got %b expected 0", fifo_rd_en); end
      tick();
   endtask

   task automatic test_stream();
      logic [11:0] vm;
      rst_n = 1'b1;
      #1;
      checks++;
      if (fifo_rd_en !== 1'b1) begin errs++; $display("FAIL first_rd_en: got %b expected 1", fifo_rd_en); end
      for (int c = 0; c < 12; c++) begin
         @(negedge rd_clk);
         vm[c] = m_valid;
         tick();
      end
      checks++;
      if (vm !== 12'h3FC) begin errs++; $display("FAIL stream_latency: valid mask %h expected 3fc", vm); end
      checks++;
      if (word_cnt !== 16'd8) begin errs++; $display("FAIL stream_count: got %0d expected 8", word_cnt); end
   endtask

   task automatic test_backpressure();
      int          pulses = 0;
      int          stall_bad = 0;
      logic [13:0] vm;
      m_ready = 1'b0;
      push_words(8'h20, 10);
      for (int c = 0; c < 12; c++) begin
         @(negedge rd_clk);
         if (fifo_rd_en) pulses++;
         if (m_valid && m_data !== 8'h20) stall_bad++;
         tick();
      end
      checks++;
      if (pulses !== 3) begin errs++; $display("FAIL stall_reads: got %0d pulses expected 3", pulses); end
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h20) begin
         errs++;
         $display("FAIL stall_head: valid=%b data=%h expected 1/20", m_valid, m_data);
      end
      checks++;
      if (stall_bad !== 0) begin errs++; $display("FAIL stall_stable: %0d unstable cycles expected 0", stall_bad); end
      m_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge rd_clk);
         vm[c] = m_valid;
         tick();
      end
      checks++;
      if (vm !== 14'h03FF) begin errs++; $display("FAIL release_burst: valid mask %h expected 03ff", vm); end
      checks++;
      if (exp_q.size() !== 0) begin errs++; $display("FAIL release_left: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_toggle();
      int d0 = dlv;
      int c  = 0;
      m_ready = 1'b1;
      push_words(8'h30, 6);
      while (exp_q.size() != 0 && c < 60) begin
         tick();
         m_ready = ~m_ready;
         c++;
      end
      m_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (exp_q.size() !== 0) begin errs++; $display("FAIL toggle_timeout: %0d left expected 0", exp_q.size()); end
      checks++;
      if (dlv - d0 !== 6) begin errs++; $display("FAIL toggle_count: got %0d expected 6", dlv - d0); end
   endtask

   task automatic test_flush();
      int n;
      m_ready = 1'b0;
      push_words(8'h40, 6);
      repeat (8) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      discard_pending(n);
      checks++;
      if (n !== 3) begin errs++; $display("FAIL flush_drop: dropped %0d expected 3", n); end
      @(negedge rd_clk);
      checks++;
      if (m_valid !== 1'b0) begin errs++; $display("FAIL flush_valid: got %b expected 0", m_valid); end
      checks++;
      if (word_cnt !== cnt_model) begin errs++; $display("FAIL flush_count: got %h expected %h", word_cnt, cnt_model); end
      m_ready = 1'b1;
      drain(40);
      push_words(8'h48, 6);
      wait_valid();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      discard_pending(n);
      checks++;
      if (n !== 1) begin errs++; $display("FAIL flush_inflight_drop: dropped %0d expected 1", n); end
      @(negedge rd_clk);
      checks++;
      if (m_valid !== 1'b0) begin errs++; $display("FAIL flush2_valid: got %b expected 0", m_valid); end
      checks++;
      if (word_cnt !== cnt_model) begin errs++; $display("FAIL flush_pop_count: got %h expected %h", word_cnt, cnt_model); end
      drain(40);
   endtask

   task automatic test_reset_mid();
      int n;
      m_ready = 1'b0;
      push_words(8'h50, 5);
      wait_valid();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid: got %b expected 0", m_valid); end
      checks++;
      if (fifo_rd_en !== 1'b0) begin errs++; $display("FAIL rst_mid_rd_en: got %b expected 0", fifo_rd_en); end
      checks++;
      if (word_cnt !== 16'h0000) begin errs++; $display("FAIL rst_mid_count: got %h expected 0000", word_cnt); end
      cnt_model = 16'h0000;
      discard_pending(n);
      checks++;
      if (n !== 3) begin errs++; $display("FAIL rst_mid_drop: dropped %0d expected 3", n); end
      tick();
      tick();
      rst_n   = 1'b1;
      m_ready = 1'b1;
      drain(40);
      checks++;
      if (word_cnt !== 16'd2) begin errs++; $display("FAIL restart_count: got %0d expected 2", word_cnt); end
   endtask

   task automatic test_wrap();
      int n = 65535 - int'(cnt_model);
      m_ready = 1'b1;
      push_words(8'h00, n);
      drain(n + 100);
      checks++;
      if (word_cnt !== 16'hFFFF) begin errs++; $display("FAIL wrap_full: got %h expected ffff", word_cnt); end
      push_words(8'hA5, 1);
      drain(40);
      checks++;
      if (word_cnt !== 16'h0000) begin errs++; $display("FAIL wrap_zero: got %h expected 0000", word_cnt); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_toggle();
      test_flush();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule
